// File: rtl/print_stream_if.sv
// Handshake bundle between printer channels, the stream arbiter and the console.
//   ch_valid/ch_data/ch_last/ch_final : per-channel beats from the printers
//   ch_ready                          : per-channel beat accept
//   out_valid/out_data/out_last/out_id: merged console stream with source tag
//   out_ready                         : console accept
// The master modport is the side that owns the printers and the console;
// the slave modport is the arbiter.
interface print_stream_if #(
  parameter int NUM_CH = 33,
  parameter int DATA_W = 8,
  parameter int ID_W   = 6
);
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_last;
  logic [NUM_CH-1:0]        ch_final;
  logic [NUM_CH-1:0]        ch_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [ID_W-1:0]          out_id;
  logic                     out_ready;

  modport master (
    output ch_valid, ch_data, ch_last, ch_final, out_ready,
    input  ch_ready, out_valid, out_data, out_last, out_id
  );

  modport slave (
    input  ch_valid, ch_data, ch_last, ch_final, out_ready,
    output ch_ready, out_valid, out_data, out_last, out_id
  );
endinterface

// File: rtl/print_stream_arbiter.sv
// Merges NUM_CH multi-beat printer message streams onto one console stream.
// Messages are granted round-robin and never interleave; every output beat
// carries its source channel ID. Channels that sent their final message are
// masked from arbitration, and all_done flags the point where every channel
// is finished and the output stage has drained.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : print_stream_if slave (channel inputs, merged output)
//   done_mask  : sticky per-channel finished flags
//   all_done   : registered "everything finished and output empty"
//   msg_count  : messages whose last beat was accepted downstream (wraps)
//
// state  | meaning
// IDLE   | choosing the next channel, no channel is ready
// LOCKED | forwarding the granted channel's message until its last beat
module print_stream_arbiter #(
  parameter int NUM_CH = 33,
  parameter int DATA_W = 8,
  parameter int ID_W   = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  print_stream_if.slave     bus,
  output logic [NUM_CH-1:0] done_mask,
  output logic              all_done,
  output logic [CNT_W-1:0]  msg_count
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]  done_mask_q, done_mask_d;
  logic               all_done_q;
  logic [CNT_W-1:0]   msg_count_q;
  logic               out_valid_q, out_last_q;
  logic [DATA_W-1:0]  out_data_q;
  logic [ID_W-1:0]    out_id_q;

  logic               found;
  logic [ID_W-1:0]    pick;
  logic [NUM_CH-1:0]  gnt_oh;
  logic               sel_valid, sel_last, sel_final;
  logic [DATA_W-1:0]  sel_data;
  logic               can_load, accept;

  // Channel index rr_ptr+k folded back into 0..NUM_CH-1; one extra bit
  // holds the sum since both operands are below NUM_CH.
  function automatic logic [ID_W-1:0] ring_idx(input logic [ID_W-1:0] base, input int k);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + (ID_W+1)'(k);
    if (sum >= (ID_W+1)'(NUM_CH)) sum = sum - (ID_W+1)'(NUM_CH);
    return sum[ID_W-1:0];
  endfunction

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && bus.ch_valid[ring_idx(rr_ptr_q, k)] && !done_mask_q[ring_idx(rr_ptr_q, k)]) begin
        found = 1'b1;
        pick  = ring_idx(rr_ptr_q, k);
      end
    end
  end

  // Granted-channel mux; gnt_oh is empty outside LOCKED so nothing is ready in IDLE.
  always_comb begin
    gnt_oh    = '0;
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_final = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q == LOCKED && grant_q == ID_W'(i)) begin
        gnt_oh[i] = 1'b1;
        sel_valid = bus.ch_valid[i];
        sel_data  = bus.ch_data[i*DATA_W +: DATA_W];
        sel_last  = bus.ch_last[i];
        sel_final = bus.ch_final[i];
      end
    end
  end

  assign can_load     = !out_valid_q || bus.out_ready;
  assign accept       = sel_valid && can_load;
  assign bus.ch_ready = gnt_oh & {NUM_CH{can_load}};

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    done_mask_d = done_mask_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          rr_ptr_d = (grant_q == ID_W'(NUM_CH-1)) ? '0 : grant_q + 1'b1;
          if (sel_final) done_mask_d = done_mask_q | gnt_oh;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      done_mask_q <= '0;
      all_done_q  <= 1'b0;
      msg_count_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      done_mask_q <= done_mask_d;
      // Uses the current output register so a final beat still in flight holds it low.
      all_done_q  <= (&done_mask_q) && !out_valid_q;
      if (out_valid_q && bus.out_ready && out_last_q) msg_count_q <= msg_count_q + 1'b1;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_last_q  <= sel_last;
        out_id_q    <= grant_q;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_last_q  <= 1'b0;
        out_id_q    <= '0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_id    = out_id_q;
  assign done_mask     = done_mask_q;
  assign all_done      = all_done_q;
  assign msg_count     = msg_count_q;

endmodule

// File: tb/tb_print_stream_arbiter.sv
module tb_print_stream_arbiter;
  localparam int NCH = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  print_stream_if #(.NUM_CH(NCH), .DATA_W(8), .ID_W(6)) bus ();
  logic [NCH-1:0] done_mask;
  logic           all_done;
  logic [15:0]    msg_count;

  print_stream_arbiter #(.NUM_CH(NCH), .DATA_W(8), .ID_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .done_mask(done_mask), .all_done(all_done), .msg_count(msg_count)
  );

  // Narrow-counter instance used to exercise the message counter wrap.
  print_stream_if #(.NUM_CH(2), .DATA_W(8), .ID_W(1)) sbus ();
  logic [1:0] s_done;
  logic       s_all_done;
  logic [3:0] s_count;

  print_stream_arbiter #(.NUM_CH(2), .DATA_W(8), .ID_W(1), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .bus(sbus.slave),
    .done_mask(s_done), .all_done(s_all_done), .msg_count(s_count)
  );

  typedef struct packed {logic [7:0] data; logic last; logic fin;} beat_t;
  typedef struct {int id; logic [7:0] data; logic last; int cyc;} obs_t;

  beat_t          drv_q[NCH][$];
  beat_t          exp_q[NCH][$];
  obs_t           log_q[$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  int             rr_model = 0;
  logic [NCH-1:0] done_model = '0;
  logic [15:0]    msg_model = '0;
  bit             in_msg = 0;
  int             cur_id = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_msg(input int ch, input string s, input bit fin);
    beat_t b;
    for (int i = 0; i < s.len(); i++) begin
      b.data = s[i];
      b.last = (i == s.len() - 1);
      b.fin  = fin && b.last;
      drv_q[ch].push_back(b);
      exp_q[ch].push_back(b);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NCH; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
    end
    log_q.delete();
    rr_model   = 0;
    done_model = '0;
    msg_model  = '0;
    in_msg     = 0;
    bus.ch_valid = '0;
    bus.ch_data  = '0;
    bus.ch_last  = '0;
    bus.ch_final = '0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NCH; i++) begin
      if (drv_q[i].size() > 0) begin
        bus.ch_valid[i]       = 1'b1;
        bus.ch_data[i*8 +: 8] = drv_q[i][0].data;
        bus.ch_last[i]        = drv_q[i][0].last;
        bus.ch_final[i]       = drv_q[i][0].fin;
      end else begin
        bus.ch_valid[i]       = 1'b0;
        bus.ch_data[i*8 +: 8] = 8'h00;
        bus.ch_last[i]        = 1'b0;
        bus.ch_final[i]       = 1'b0;
      end
    end
  endtask

  // Reference: a message starts on the first channel at/after the round-robin
  // pointer that still has an unsent message and has not finished.
  task automatic score_beat();
    int    id;
    int    exp_id;
    beat_t b;
    obs_t  o;
    id = int'(bus.out_id);
    if (!in_msg) begin
      exp_id = -1;
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (rr_model + k) % NCH;
        if (exp_id < 0 && exp_q[c].size() > 0 && !done_model[c]) exp_id = c;
      end
      chk("rr_order", 64'(id), 64'(exp_id));
    end else begin
      chk("no_interleave", 64'(id), 64'(cur_id));
    end
    checks++;
    assert (id < NCH && exp_q[id % NCH].size() > 0) else begin
      errors++;
      $error("FAIL beat_expected: channel %0d emitted %0h with nothing pending", id, bus.out_data);
    end
    if (id < NCH && exp_q[id].size() > 0) begin
      b = exp_q[id].pop_front();
      chk("out_data", 64'(bus.out_data), 64'(b.data));
      chk("out_last", 64'(bus.out_last), 64'(b.last));
      if (b.last) begin
        msg_model++;
        rr_model = (id + 1) % NCH;
        if (b.fin) done_model[id] = 1'b1;
        in_msg = 0;
      end else begin
        in_msg = 1;
        cur_id = id;
      end
    end
    o.id = id; o.data = bus.out_data; o.last = bus.out_last; o.cyc = cyc;
    log_q.push_back(o);
  endtask

  task automatic step(input bit ordy);
    @(negedge clk);
    cyc++;
    drive_inputs();
    bus.out_ready = ordy;
    #1;
    chk("msg_count", 64'(msg_count), 64'(msg_model));
    chk("ready_onehot", 64'($countones(bus.ch_ready) <= 1), 64'd1);
    if (bus.out_valid && !ordy) chk("stall_ready", 64'(bus.ch_ready), 64'd0);
    if (bus.out_valid && ordy) score_beat();
    for (int i = 0; i < NCH; i++)
      if (bus.ch_valid[i] && bus.ch_ready[i]) void'(drv_q[i].pop_front());
  endtask

  task automatic run_beats(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      step(1'b1);
      k++;
    end
    chk(tag, 64'(log_q.size()), 64'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat [8];
    int         ids [6];
    logic [3:0] cnt_model;
    logic [3:0] prev_cnt;
    int         wraps;
    int         k;
    bit         pending;

    bus.out_ready  = 1'b0;
    sbus.ch_valid  = '0;
    sbus.ch_data   = '0;
    sbus.ch_last   = '0;
    sbus.ch_final  = '0;
    sbus.out_ready = 1'b0;
    clear_all();
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_msg_count", 64'(msg_count), 64'd0);
    chk("rst_done_mask", 64'(done_mask), 64'd0);
    chk("rst_all_done", 64'(all_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: three channels send "HI" together
    load_msg(0, "HI", 1);
    load_msg(5, "HI", 1);
    load_msg(32, "HI", 1);
    run_beats("t1_beats", 6, 40);
    ids = '{0, 0, 5, 5, 32, 32};
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      chk("t1_id", 64'(log_q[i].id), 64'(ids[i]));
      chk("t1_last", 64'(log_q[i].last), 64'(i % 2));
    end
    step(1'b1);
    chk("t1_msg_count", 64'(msg_count), 64'd3);
    chk("t1_done_mask", 64'(done_mask), 64'h1_0000_0021);
    chk("t1_all_done", 64'(all_done), 64'd0);

    // 2: fairness between channels 3 and 4
    log_q.delete();
    for (int m = 0; m < 5; m++) begin
      load_msg(3, "a", 0);
      load_msg(4, "b", 0);
    end
    run_beats("t2_beats", 10, 60);
    for (int i = 0; i < log_q.size(); i++) begin
      chk("t2_alt", 64'(log_q[i].id), 64'((i % 2 == 0) ? 3 : 4));
      if (i > 0) chk("t2_gap", 64'(log_q[i].cyc - log_q[i-1].cyc), 64'd2);
    end

    // 3: backpressure on channel 7
    log_q.delete();
    load_msg(7, "ABCD", 0);
    pat = '{1, 0, 0, 1, 1, 0, 1, 1};
    for (int i = 0; i < 8; i++) step(pat[i][0]);
    run_beats("t3_beats", 4, 20);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk("t3_data", 64'(log_q[i].data), 64'(8'h41 + i));
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("t3_no_dup", 64'(log_q.size()), 64'd4);

    // 4: asynchronous reset in the middle of a message on channel 9
    log_q.delete();
    load_msg(9, "WXYZ", 0);
    run_beats("t4_beats", 2, 20);
    rst = 1'b1;
    #1;
    chk("t4_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_out_data", 64'(bus.out_data), 64'd0);
    chk("t4_out_last", 64'(bus.out_last), 64'd0);
    chk("t4_out_id", 64'(bus.out_id), 64'd0);
    chk("t4_ch_ready", 64'(bus.ch_ready), 64'd0);
    chk("t4_done_mask", 64'(done_mask), 64'd0);
    chk("t4_msg_count", 64'(msg_count), 64'd0);
    clear_all();
    @(negedge clk);
    rst = 1'b0;
    load_msg(30, "R", 0);
    load_msg(1, "Q", 0);
    run_beats("t4_after_beats", 2, 20);
    if (log_q.size() == 2) begin
      chk("t4_first", 64'(log_q[0].id), 64'd1);
      chk("t4_second", 64'(log_q[1].id), 64'd30);
    end

    // 5: every channel sends one final message
    do_reset();
    for (int i = 0; i < NCH; i++) load_msg(i, "!", 1);
    run_beats("t5_beats", NCH, 200);
    chk("t5_all_done_s0", 64'(all_done), 64'd0);
    step(1'b1);
    chk("t5_all_done_s1", 64'(all_done), 64'd0);
    chk("t5_msg_count", 64'(msg_count), 64'd33);
    chk("t5_done_mask", 64'(done_mask), {31'd0, {NCH{1'b1}}});
    step(1'b1);
    chk("t5_all_done_s2", 64'(all_done), 64'd1);
    for (int i = 0; i < NCH; i++) drv_q[i].push_back(beat_t'{8'h3f, 1'b1, 1'b0});
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      chk("t5_ignored", 64'(bus.ch_ready), 64'd0);
    end

    // 6: grant latency on the main instance
    do_reset();
    load_msg(2, "Z", 0);
    step(1'b1);
    chk("t6_ready_t", 64'(bus.ch_ready[2]), 64'd0);
    step(1'b1);
    chk("t6_ready_t1", 64'(bus.ch_ready[2]), 64'd1);
    chk("t6_valid_t1", 64'(bus.out_valid), 64'd0);
    step(1'b1);
    chk("t6_valid_t2", 64'(bus.out_valid), 64'd1);
    chk("t6_id_t2", 64'(bus.out_id), 64'd2);

    // 6b: counter wrap on the narrow instance
    sbus.ch_valid  = 2'b01;
    sbus.ch_last   = 2'b01;
    sbus.ch_data   = 16'h0041;
    sbus.out_ready = 1'b1;
    cnt_model = '0;
    prev_cnt  = '0;
    wraps     = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      chk("wrap_count", 64'(s_count), 64'(cnt_model));
      if (prev_cnt == 4'hF && s_count == 4'h0) wraps++;
      prev_cnt = s_count;
      if (sbus.out_valid && sbus.out_last) cnt_model = cnt_model + 4'd1;
    end
    chk("wrap_seen", 64'(wraps), 64'd1);
    sbus.ch_valid = '0;

    // 7: randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int nmsg;
        nmsg = $urandom_range(1, 3);
        for (int m = 0; m < nmsg; m++) begin
          string s;
          s = "";
          for (int j = 0; j < $urandom_range(1, 4); j++) s = {s, "x"};
          for (int j = 0; j < s.len(); j++) s[j] = 8'($urandom_range(32, 126));
          load_msg(c, s, (m == nmsg - 1) && ($urandom_range(0, 1) == 1));
        end
      end
    end
    k = 0;
    pending = 1;
    while (pending && k < 3000) begin
      step($urandom_range(0, 3) != 0);
      k++;
      pending = 0;
      for (int c = 0; c < NCH; c++) if (exp_q[c].size() > 0) pending = 1;
    end
    chk("rand_drained", 64'(pending), 64'd0);
    step(1'b1);
    chk("rand_msg_count", 64'(msg_count), 64'(msg_model));
    chk("rand_done_mask", 64'(done_mask), 64'(done_model));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/print_stream_arbiter.md
Name: print_stream_arbiter

Overview:
- Parametrised successor to the flat bank of free-running printer instances. Each of NUM_CH printer channels sends multi-beat character messages over valid/ready. The block merges them onto one console stream.
- Messages are arbitrated round-robin and never interleave.
- Each output beat is tagged with its source channel ID.
- Tracks per-channel completion and raises all_done, so the testbench top can end simulation once every printer has finished.

Parameters:
- NUM_CH, 33, number of printer channels (2..64)
- DATA_W, 8, character width in bits
- ID_W, 6, width of the channel ID tag; must satisfy 2^ID_W >= NUM_CH
- CNT_W, 16, width of the accepted-message counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ch_valid  in  NUM_CH  per-channel beat valid
- ch_data  in  NUM_CH*DATA_W  per-channel character; channel i occupies bits [i*DATA_W +: DATA_W]
- ch_last  in  NUM_CH  final beat of the message
- ch_final  in  NUM_CH  sampled together with ch_last: this message is the channel's last
- ch_ready  out  NUM_CH  per-channel beat accept
- out_valid  out  1  output beat valid
- out_data  out  DATA_W  output character
- out_last  out  1  final beat of the current message
- out_id  out  ID_W  source channel of the beat
- out_ready  in  1  downstream accept
- done_mask  out  NUM_CH  sticky per-channel finished flags
- all_done  out  1  every channel has finished and the output register is empty
- msg_count  out  CNT_W  number of messages whose last beat was accepted downstream

Behaviour:
- Reset (async, active-high): every output is 0, the FSM enters IDLE, and rr_ptr = 0. A partially forwarded message is dropped with no recovery.
- Transfers: a beat transfers when valid && ready, on each channel and on the output.
- Channel input rules:
  - ch_valid and its payload must stay stable until accepted.
  - ch_ready never depends combinationally on ch_valid of the same channel.
- FSM IDLE:
  - Candidate channels: ch_valid[i] = 1 and done_mask[i] = 0.
  - Pick the first candidate at or after rr_ptr, searching upward with wrap from NUM_CH-1 to 0.
  - Register it as grant and move to LOCKED at the next edge.
  - No candidate: stay in IDLE.
  - ch_ready = 0 for all channels while in IDLE.
- FSM LOCKED:
  - ch_ready[grant] = (!out_valid || out_ready); every other ch_ready = 0.
  - An accepted beat loads the output register: data, last and id = grant.
  - When a beat with ch_last = 1 is accepted:
    - rr_ptr = (grant == NUM_CH-1) ? 0 : grant+1.
    - If ch_final = 1, set done_mask[grant].
    - Return to IDLE; there is no same-cycle re-arbitration.
- Output register:
  - One stage.
  - Cleared when out_ready = 1 and no new beat is loaded.
  - Holds its value while out_valid && !out_ready.
- Latency:
  - ch_valid rising in IDLE at edge t gives grant at t+1, the first ch_ready during cycle t+1, and out_valid from t+2.
  - Sustained throughput within a message: 1 beat/cycle.
  - Inter-message gap: at least 1 cycle (the IDLE cycle).
- msg_count:
  - Increments when out_valid && out_ready && out_last.
  - Wraps modulo 2^CNT_W.
- all_done is registered: it goes high the cycle after done_mask is all ones and out_valid = 0.
- done channels: once done_mask[i] = 1, channel i is never granted again; any later ch_valid on it is ignored and left unaccepted.
- Simultaneous requests: resolved strictly by rr_ptr order.
- Backpressure with out_ready = 0 for N cycles: the output register holds and ch_ready[grant] = 0. No beat is lost or duplicated.
- Single-beat message (ch_last on the first beat): LOCKED lasts exactly 1 cycle.

Test Plan:
1. Reset, then channels 0, 5 and 32 each send "HI" (2 beats; last on beat 2, final = 1), all valid together, out_ready = 1.
   - Output order: ch 0, 5, 32, with out_id 0,0,5,5,32,32 and out_last on beats 2, 4 and 6.
   - msg_count = 3.
   - done_mask bits 0, 5 and 32 set; all_done = 0.
2. Fairness: channels 3 and 4 each stream five 1-beat messages (final = 0) continuously.
   - out_id alternates 3,4,3,4,…
   - Each message takes 2 cycles (one IDLE gap).
3. Backpressure: channel 7 sends "ABCD"; out_ready is driven 1,0,0,1,1,0,1,1.
   - Output is exactly A,B,C,D with no duplicates.
   - ch_ready[7] = 0 on every cycle the register is full and stalled.
4. Async reset asserted mid-message on channel 9 (after beat 2 of 4).
   - All outputs 0 immediately, without waiting for a clock edge.
   - After release, channel 1 requests and is granted first, since rr_ptr = 0.
5. All 33 channels send a 1-beat final message.
   - msg_count = 33 and done_mask = all ones.
   - all_done rises 1 cycle after the last beat is accepted.
   - Further ch_valid on any channel produces no ch_ready.
6. ch_valid rises at edge t in IDLE:
   - ch_ready is high in cycle t+1.
   - out_valid is high at t+2.
   - msg_count wraps from 0xFFFF to 0 when a message completes at that value.
